counter_element: RTL
====================

Name: counter_element

Overview:
- Counting element for one 8254 counter channel. Sits directly downstream of the per-channel control logic and consumes its count_enable, load_new_count, CR_enable, CR_reset, OL_enable and read_count_enable strobes.
- Holds the count register (CR), the counting element (CE) and the output latch (OL).
- Returns initial_count, current_count and count_loaded to the control logic, and drives the read byte toward the data bus buffer.

Parameters:
- DATA_W, 8, data-bus byte width
- CNT_W, 16, count register / counting element width (must equal 2*DATA_W)

Ports:
- clk  input  1  counter clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- data_in  input  8  write byte from data bus buffer
- CR_enable  input  2  CR byte write strobes: bit0 = LSB, bit1 = MSB; one-cycle pulses
- CR_reset  input  1  clears CR and the null-count state
- load_new_count  input  1  transfer CR→CE on this clock edge
- count_enable  input  1  decrement CE on this clock edge
- mode  input  3  counter mode from status byte [3:1]
- bcd  input  1  1 = BCD counting, 0 = binary
- OL_enable  input  2  per-byte OL follow enable: 1 = track CE, 0 = hold
- read_count_enable  input  2  01 = OL LSB, 10 = OL MSB, else 00 on data_out
- read_status_enable  input  1  select status_in onto data_out
- status_in  input  8  latched status byte
- initial_count  output  16  current CR contents
- current_count  output  16  current CE contents
- count_loaded  output  1  0 = null count (CR written since last CE load)
- data_out  output  8  read byte

Behaviour:
- Reset (rst_n low, async):
  - CR = 0, CE = 0, OL = 0, count_loaded = 0, data_out = 0.
  - Reset asserted mid-count aborts all activity immediately.
- CR writes:
  - CR_enable[0] writes data_in to CR[7:0]; CR_enable[1] writes data_in to CR[15:8]. Both may be set in the same cycle.
  - Any CR write clears count_loaded on that edge.
- CR_reset:
  - Sets CR = 0 and count_loaded = 0.
  - Has priority over a CR write in the same cycle.
- CE update priority per edge: load_new_count > count_enable > hold.
- Load:
  - CE ← CR and count_loaded ← 1.
  - In mode 3 (mode = 3'b011 or 3'b111), CE ← {CR[15:1], 1'b0}, i.e. odd counts load one less.
  - A CR write in the same cycle as a load is not seen by that load: CE takes the pre-write CR. count_loaded ends at 0 because the write wins.
- Decrement:
  - Step is 2 in mode 3 and 1 in all other modes.
  - Binary: modulo 2^16, so 0000 − 1 = FFFF and 0000 − 2 = FFFE.
  - BCD: four-digit decimal with per-nibble borrow, so 0000 − 1 = 9999, 0000 − 2 = 9998 and 0100 − 1 = 0099.
  - CR = 0 therefore counts as 65536 (binary) or 10000 (BCD).
  - BCD behaviour with illegal nibbles (A–F) is undefined.
- Output latch:
  - Each clock, OL[7:0] ← CE[7:0] if OL_enable[0], else hold; OL[15:8] ← CE[15:8] if OL_enable[1], else hold.
  - OL reflects CE one cycle late while following.
  - A latch command (OL_enable → 00) freezes the value CE had on the preceding edge.
- data_out:
  - Combinational from registered sources.
  - Priority: read_status_enable → status_in; read_count_enable = 01 → OL[7:0]; 10 → OL[15:8]; otherwise 8'h00.
- initial_count = CR; current_count = CE (direct register outputs, zero latency).
- No internal mode FSM: reload timing is owned by the control logic.

Optional Feature:
- Macro: COUNTER_TC_FLAG_EN.
- Defined:
  - Adds output tc_pulse (1 bit, reset 0).
  - tc_pulse is high for exactly one cycle, on the edge after a decrement makes CE equal 0000.
  - A load that leaves CE at 0000 does not assert it.
- Undefined: tc_pulse port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low with CE = 1234 → CE, CR, OL and data_out all 0 immediately, count_loaded = 0.
- Binary mode 0:
  - Write LSB 05 then MSB 00, pulse load_new_count → count_loaded = 1 and CE = 0005.
  - Five count_enable cycles → CE = 0000; sixth → FFFF.
- BCD mode 2:
  - CR = 0100, load, one decrement → CE = 0099.
  - CR = 0000, load, one decrement → CE = 9999.
- Mode 3:
  - CR = 0007, load → CE = 0006; decrements give 0004, 0002, 0000, FFFE.
  - CR = 0008 → CE = 0008.
- Latch and read:
  - CE counting down from 0300; drop OL_enable to 00 while CE = 0250.
  - After 10 further decrements, read_count_enable = 01 → data_out = 50; read_count_enable = 10 → data_out = 02.
  - read_status_enable with status_in = 36 → data_out = 36.
- Simultaneous events:
  - CR = 0010 loaded; CR_enable = 01 with data_in = 20 in the same cycle as load_new_count → CE = 0010, CR = 0020, count_loaded = 0.
  - CR_reset together with CR_enable → CR = 0000.

Source files
------------

// File: rtl/counter_element.sv
// 8254 per-channel counting element: count register (CR), counting element (CE), output latch (OL).
// Optional macro COUNTER_TC_FLAG_EN adds a one-cycle tc_pulse output when a decrement reaches zero.
module counter_element #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        CR_enable,
  input  logic              CR_reset,
  input  logic              load_new_count,
  input  logic              count_enable,
  input  logic [2:0]        mode,
  input  logic              bcd,
  input  logic [1:0]        OL_enable,
  input  logic [1:0]        read_count_enable,
  input  logic              read_status_enable,
  input  logic [DATA_W-1:0] status_in,
  output logic [CNT_W-1:0]  initial_count,
  output logic [CNT_W-1:0]  current_count,
  output logic              count_loaded,
  output logic [DATA_W-1:0] data_out
`ifdef COUNTER_TC_FLAG_EN
  ,
  output logic              tc_pulse
`endif
);

  logic [CNT_W-1:0] cr_q, cr_d;
  logic [CNT_W-1:0] ce_q, ce_d;
  logic [CNT_W-1:0] ol_q, ol_d;
  logic             loaded_q, loaded_d;
  logic             mode3;
  logic [1:0]       step;
  logic [CNT_W-1:0] dec_val;

  // Four-digit decimal subtract with per-nibble borrow; only the lowest digit takes the step.
  function automatic logic [CNT_W-1:0] bcd_sub(input logic [CNT_W-1:0] v,
                                               input logic [1:0]       s);
    logic [CNT_W-1:0] r;
    logic [4:0]       d;
    logic             borrow;
    r      = '0;
    borrow = 1'b0;
    for (int unsigned i = 0; i < CNT_W / 4; i++) begin
      d = {1'b0, v[i*4 +: 4]} - ((i == 0) ? {3'b000, s} : 5'd0) - {4'b0000, borrow};
      if (d[4]) begin
        d      = d + 5'd10;
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      r[i*4 +: 4] = d[3:0];
    end
    return r;
  endfunction

  assign mode3   = (mode == 3'b011) || (mode == 3'b111);
  assign step    = mode3 ? 2'd2 : 2'd1;
  assign dec_val = bcd ? bcd_sub(ce_q, step) : (ce_q - CNT_W'(step));

  always_comb begin
    cr_d     = cr_q;
    loaded_d = loaded_q;
    ce_d     = ce_q;
    ol_d     = ol_q;

    // Load uses the registered CR, so a same-cycle write is not seen by the load.
    if (load_new_count) begin
      ce_d     = mode3 ? {cr_q[CNT_W-1:1], 1'b0} : cr_q;
      loaded_d = 1'b1;
    end else if (count_enable) begin
      ce_d = dec_val;
    end

    if (CR_reset) begin
      cr_d     = '0;
      loaded_d = 1'b0;
    end else if (CR_enable != 2'b00) begin
      if (CR_enable[0]) cr_d[0      +: DATA_W] = data_in;
      if (CR_enable[1]) cr_d[DATA_W +: DATA_W] = data_in;
      loaded_d = 1'b0;
    end

    if (OL_enable[0]) ol_d[0      +: DATA_W] = ce_q[0      +: DATA_W];
    if (OL_enable[1]) ol_d[DATA_W +: DATA_W] = ce_q[DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q     <= '0;
      ce_q     <= '0;
      ol_q     <= '0;
      loaded_q <= 1'b0;
    end else begin
      cr_q     <= cr_d;
      ce_q     <= ce_d;
      ol_q     <= ol_d;
      loaded_q <= loaded_d;
    end
  end

`ifdef COUNTER_TC_FLAG_EN
  logic tc_q, tc_d;

  assign tc_d = !load_new_count && count_enable && (dec_val == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc_q <= 1'b0;
    else        tc_q <= tc_d;
  end

  assign tc_pulse = tc_q;
`endif

  always_comb begin
    data_out = '0;
    if (read_status_enable)              data_out = status_in;
    else if (read_count_enable == 2'b01) data_out = ol_q[0      +: DATA_W];
    else if (read_count_enable == 2'b10) data_out = ol_q[DATA_W +: DATA_W];
  end

  assign initial_count = cr_q;
  assign current_count = ce_q;
  assign count_loaded  = loaded_q;

endmodule
